// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl
// N-channel ADC capture controller. Writes raw sample words into a ping-pong
// DPBRAM (continuous wrap or triggered single-shot), raises half/full flags
// with PS acknowledge and sticky overrun, and keeps a per-channel moving sum
// over a 2^SUM_LOG2-sample window.

module adc_capture_ctrl #(
    parameter int NCH       = 2,
    parameter int DW        = 24,
    parameter int RAM_DEPTH = 20000,
    parameter int SUM_LOG2  = 3,
    parameter int AW        = $clog2(RAM_DEPTH)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_enable,
    input  logic                i_mode,
    input  logic                i_trig,
    input  logic                i_smp_valid,
    input  logic [NCH*DW-1:0]   i_smp_data,
    input  logic [1:0]          i_flag_ack,
    output logic [AW-1:0]       o_ram_addr,
    output logic                o_ram_ce,
    output logic                o_ram_we,
    output logic [NCH*DW-1:0]   o_ram_dout,
    output logic                o_flag_1,
    output logic                o_flag_2,
    output logic                o_overrun,
    output logic [NCH*32-1:0]   o_sum_data,
    output logic                o_sum_valid,
    output logic [1:0]          o_debug_state
);

    localparam int SUM_W  = 32;
    localparam int HIST_N = 1 << SUM_LOG2;

    localparam logic [AW-1:0] LAST_ADDR      = AW'(RAM_DEPTH - 1);
    localparam logic [AW-1:0] HALF_LAST_ADDR = AW'(RAM_DEPTH / 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // Sign-extend one raw sample into the moving-sum accumulator width.
    function automatic logic signed [SUM_W-1:0] sext_smp(input logic signed [DW-1:0] x);
        return SUM_W'(x);
    endfunction

    // Write pointer advance; wraps after the last RAM location.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_mode;
    logic                    w_wr_accept;
    logic                    w_start;
    logic [1:0]              w_debug_state;

    // ------------------------------------------------------------------
    // Write pipeline (p0 = input strobe, p1 = RAM port drive)
    // ------------------------------------------------------------------
    logic [AW-1:0]           r_wr_ptr;
    logic                    r_wr_vld_p1;
    logic [AW-1:0]           r_wr_addr_p1;
    logic [NCH*DW-1:0]       r_wr_data_p1;

    // ------------------------------------------------------------------
    // Flags
    // ------------------------------------------------------------------
    logic [1:0]              r_flag;
    logic                    r_overrun;
    logic [1:0]              w_set;

    // ------------------------------------------------------------------
    // Moving sum
    // ------------------------------------------------------------------
    logic signed [DW-1:0]    w_smp_p0 [NCH];
    logic signed [DW-1:0]    r_hist   [NCH][HIST_N];
    logic signed [SUM_W-1:0] r_sum_p1 [NCH];
    logic                    r_sum_vld_p1;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; dropping enable returns to IDLE from any state
    always_comb begin
        w_state_nxt = r_state;
        if (!i_enable) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    w_state_nxt = i_mode ? S_ARM : S_CAPTURE;
                S_ARM:     if (i_trig) w_state_nxt = S_CAPTURE;
                S_CAPTURE: if (w_wr_accept && r_mode && (r_wr_ptr == LAST_ADDR))
                               w_state_nxt = S_DONE;
                S_DONE:    w_state_nxt = S_DONE;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State-derived control: write acceptance and IDLE->active start pulse
    always_comb begin
        w_wr_accept   = (r_state == S_CAPTURE) && i_enable && i_smp_valid;
        w_start       = (r_state == S_IDLE) && i_enable;
        w_debug_state = r_state;
    end

    // Capture mode is frozen for the whole run once IDLE is left
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mode <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_mode <= i_mode;
        end
    end

    // --- stage p0 -> p1: register accepted sample and its RAM address ---
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_enable) begin
            r_wr_ptr     <= '0;
            r_wr_vld_p1  <= 1'b0;
            r_wr_addr_p1 <= '0;
        end else begin
            r_wr_vld_p1 <= w_wr_accept;
            if (w_wr_accept) begin
                r_wr_addr_p1 <= r_wr_ptr;
                r_wr_ptr     <= next_addr(r_wr_ptr);
            end
        end
    end

    // Write data follows the accepted strobe; held between writes
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_data_p1 <= '0;
        end else if (w_wr_accept) begin
            r_wr_data_p1 <= i_smp_data;
        end
    end

    // A flag is raised by the RAM write that completes its half
    assign w_set[0] = r_wr_vld_p1 && (r_wr_addr_p1 == HALF_LAST_ADDR);
    assign w_set[1] = r_wr_vld_p1 && (r_wr_addr_p1 == LAST_ADDR);

    // Half/full flags with PS acknowledge; set wins over a coincident ack
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_flag    <= 2'b00;
            r_overrun <= 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (w_set[k]) begin
                    r_flag[k] <= 1'b1;
                end else if (i_flag_ack[k]) begin
                    r_flag[k] <= 1'b0;
                end
            end
            if (w_start) begin
                r_overrun <= 1'b0;
            end else if (|(w_set & r_flag & ~i_flag_ack)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Unpack the per-channel samples; ch0 sits in the LSBs
    for (genvar ch = 0; ch < NCH; ch++) begin : g_unpack
        assign w_smp_p0[ch] = i_smp_data[ch*DW +: DW];
        assign o_sum_data[ch*SUM_W +: SUM_W] = r_sum_p1[ch];
    end

    // --- stage p0 -> p1: running window sum; an empty history slot reads 0 ---
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_enable) begin
            for (int ch = 0; ch < NCH; ch++) begin
                for (int t = 0; t < HIST_N; t++) begin
                    r_hist[ch][t] <= '0;
                end
                r_sum_p1[ch] <= '0;
            end
            r_sum_vld_p1 <= 1'b0;
        end else begin
            r_sum_vld_p1 <= i_smp_valid;
            if (i_smp_valid) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    r_sum_p1[ch] <= r_sum_p1[ch] + sext_smp(w_smp_p0[ch])
                                    - sext_smp(r_hist[ch][HIST_N-1]);
                    for (int t = HIST_N - 1; t > 0; t--) begin
                        r_hist[ch][t] <= r_hist[ch][t-1];
                    end
                    r_hist[ch][0] <= w_smp_p0[ch];
                end
            end
        end
    end

    assign o_ram_addr    = r_wr_addr_p1;
    assign o_ram_ce      = r_wr_vld_p1;
    assign o_ram_we      = 1'b1;
    assign o_ram_dout    = r_wr_data_p1;
    assign o_flag_1      = r_flag[0];
    assign o_flag_2      = r_flag[1];
    assign o_overrun     = r_overrun;
    assign o_sum_valid   = r_sum_vld_p1;
    assign o_debug_state = w_debug_state;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl
// Directed bench for adc_capture_ctrl (NCH=2, DW=24, RAM_DEPTH=16, SUM_LOG2=2).
// Stimulus pushes expected RAM writes and moving sums into queues; a monitor
// pops and compares whenever the DUT presents o_ram_ce or o_sum_valid.

module tb_adc_capture_ctrl;

    localparam int NCH       = 2;
    localparam int DW        = 24;
    localparam int RAM_DEPTH = 16;
    localparam int SUM_LOG2  = 2;
    localparam int AW        = 4;

    logic                i_clk = 1'b0;
    logic                i_rst;
    logic                i_enable;
    logic                i_mode;
    logic                i_trig;
    logic                i_smp_valid;
    logic [NCH*DW-1:0]   i_smp_data;
    logic [1:0]          i_flag_ack;
    logic [AW-1:0]       o_ram_addr;
    logic                o_ram_ce;
    logic                o_ram_we;
    logic [NCH*DW-1:0]   o_ram_dout;
    logic                o_flag_1;
    logic                o_flag_2;
    logic                o_overrun;
    logic [NCH*32-1:0]   o_sum_data;
    logic                o_sum_valid;
    logic [1:0]          o_debug_state;

    adc_capture_ctrl #(
        .NCH       (NCH),
        .DW        (DW),
        .RAM_DEPTH (RAM_DEPTH),
        .SUM_LOG2  (SUM_LOG2)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_enable      (i_enable),
        .i_mode        (i_mode),
        .i_trig        (i_trig),
        .i_smp_valid   (i_smp_valid),
        .i_smp_data    (i_smp_data),
        .i_flag_ack    (i_flag_ack),
        .o_ram_addr    (o_ram_addr),
        .o_ram_ce      (o_ram_ce),
        .o_ram_we      (o_ram_we),
        .o_ram_dout    (o_ram_dout),
        .o_flag_1      (o_flag_1),
        .o_flag_2      (o_flag_2),
        .o_overrun     (o_overrun),
        .o_sum_data    (o_sum_data),
        .o_sum_valid   (o_sum_valid),
        .o_debug_state (o_debug_state)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [AW-1:0]     addr;
        logic [NCH*DW-1:0] data;
    } wr_t;

    typedef struct packed {
        logic [31:0] s0;
        logic [31:0] s1;
    } sum_t;

    wr_t  wq[$];
    sum_t sq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   h0[4];
    int   h1[4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic int sx(input logic [23:0] d);
        return int'({{8{d[23]}}, d});
    endfunction

    task automatic clr_model();
        for (int k = 0; k < 4; k++) begin
            h0[k] = 0;
            h1[k] = 0;
        end
    endtask

    // One strobe followed by an idle cycle; ack (if any) is driven during the
    // RAM write cycle of this strobe.
    task automatic strobe_x(input logic [23:0] d0, input logic [23:0] d1,
                            input bit wr, input int addr, input bit trg,
                            input logic [1:0] ack, input bit ovr,
                            input int e0, input int e1);
        sum_t s;
        wr_t  w;
        for (int k = 3; k > 0; k--) begin
            h0[k] = h0[k-1];
            h1[k] = h1[k-1];
        end
        h0[0] = sx(d0);
        h1[0] = sx(d1);
        if (ovr) begin
            s.s0 = 32'(e0);
            s.s1 = 32'(e1);
        end else begin
            s.s0 = 32'(h0[0] + h0[1] + h0[2] + h0[3]);
            s.s1 = 32'(h1[0] + h1[1] + h1[2] + h1[3]);
        end
        sq.push_back(s);
        if (wr) begin
            w.addr = AW'(addr);
            w.data = {d1, d0};
            wq.push_back(w);
        end
        i_smp_data  = {d1, d0};
        i_smp_valid = 1'b1;
        i_trig      = trg;
        tick();
        i_smp_valid = 1'b0;
        i_trig      = 1'b0;
        i_flag_ack  = ack;
        chk("ce_latency", 64'(o_ram_ce), 64'(wr));
        chk("sum_vld_latency", 64'(o_sum_valid), 64'd1);
        tick();
        i_flag_ack = 2'b00;
        chk("sum_vld_pulse", 64'(o_sum_valid), 64'd0);
    endtask

    task automatic strobe(input logic [23:0] d0, input logic [23:0] d1,
                          input bit wr, input int addr);
        strobe_x(d0, d1, wr, addr, 1'b0, 2'b00, 1'b0, 0, 0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a write or a sum
    always @(negedge i_clk) begin
        if (o_ram_ce === 1'b1) begin
            if (wq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0d data 0x%0h, no write expected",
                         o_ram_addr, o_ram_dout);
            end else begin
                wr_t e;
                e = wq.pop_front();
                chk("wr_addr", 64'(o_ram_addr), 64'(e.addr));
                chk("wr_data", 64'(o_ram_dout), 64'(e.data));
            end
        end
        if (o_sum_valid === 1'b1) begin
            if (sq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_sum: 0x%0h, no sum expected", o_sum_data);
            end else begin
                sum_t e;
                e = sq.pop_front();
                chk("sum_ch0", 64'(o_sum_data[31:0]), 64'(e.s0));
                chk("sum_ch1", 64'(o_sum_data[63:32]), 64'(e.s1));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst       = 1'b1;
        i_enable    = 1'b0;
        i_mode      = 1'b0;
        i_trig      = 1'b0;
        i_smp_valid = 1'b0;
        i_smp_data  = '0;
        i_flag_ack  = 2'b00;
        clr_model();
        repeat (3) tick();

        // Reset state
        chk("rst_addr",    64'(o_ram_addr),    64'd0);
        chk("rst_ce",      64'(o_ram_ce),      64'd0);
        chk("rst_we",      64'(o_ram_we),      64'd1);
        chk("rst_dout",    64'(o_ram_dout),    64'd0);
        chk("rst_flag1",   64'(o_flag_1),      64'd0);
        chk("rst_flag2",   64'(o_flag_2),      64'd0);
        chk("rst_overrun", 64'(o_overrun),     64'd0);
        chk("rst_sum",     64'(o_sum_data),    64'd0);
        chk("rst_sum_vld", 64'(o_sum_valid),   64'd0);
        chk("rst_state",   64'(o_debug_state), 64'd0);
        i_rst = 1'b0;
        tick();
        chk("idle_hold", 64'(o_debug_state), 64'd0);

        // Mode 0: one full lap, then half a lap without ack
        i_mode   = 1'b0;
        i_enable = 1'b1;
        tick();
        chk("m0_state", 64'(o_debug_state), 64'd2);
        for (int i = 0; i < 16; i++) begin
            strobe(24'(i), 24'hFFFFFF, 1'b1, i);
            chk("m0_flag1", 64'(o_flag_1), 64'(i >= 7));
            chk("m0_flag2", 64'(o_flag_2), 64'(i >= 15));
        end
        chk("m0_no_overrun", 64'(o_overrun), 64'd0);
        for (int i = 16; i < 24; i++) begin
            strobe(24'(i), 24'hFFFFFF, 1'b1, i - 16);
            chk("m0_overrun", 64'(o_overrun), 64'(i == 23));
        end

        // Disable keeps flags and overrun; re-enable clears overrun
        i_enable = 1'b0;
        tick();
        clr_model();
        chk("dis_state",   64'(o_debug_state), 64'd0);
        chk("dis_addr",    64'(o_ram_addr),    64'd0);
        chk("dis_flag1",   64'(o_flag_1),      64'd1);
        chk("dis_flag2",   64'(o_flag_2),      64'd1);
        chk("dis_overrun", 64'(o_overrun),     64'd1);
        chk("dis_sum",     64'(o_sum_data),    64'd0);
        i_enable = 1'b1;
        tick();
        chk("reen_overrun", 64'(o_overrun),     64'd0);
        chk("reen_state",   64'(o_debug_state), 64'd2);

        // Ack coincident with flag_1 re-set: stays set, no overrun
        for (int i = 0; i < 7; i++) strobe(24'(100 + i), 24'(i), 1'b1, i);
        strobe_x(24'd107, 24'd7, 1'b1, 7, 1'b0, 2'b01, 1'b0, 0, 0);
        chk("ackset_flag1",   64'(o_flag_1),  64'd1);
        chk("ackset_overrun", 64'(o_overrun), 64'd0);
        strobe(24'd108, 24'd8, 1'b1, 8);

        // Enable dropped at pointer 9 with flag_1 set
        i_enable = 1'b0;
        tick();
        clr_model();
        chk("drop9_state", 64'(o_debug_state), 64'd0);
        chk("drop9_addr",  64'(o_ram_addr),    64'd0);
        chk("drop9_flag1", 64'(o_flag_1),      64'd1);

        // Ack without a set clears the flag on the next cycle
        i_flag_ack = 2'b01;
        tick();
        i_flag_ack = 2'b00;
        chk("ack_clr_flag1",  64'(o_flag_1), 64'd0);
        chk("ack_keep_flag2", 64'(o_flag_2), 64'd1);
        i_flag_ack = 2'b10;
        tick();
        i_flag_ack = 2'b00;
        chk("ack_clr_flag2", 64'(o_flag_2), 64'd0);

        // Mode 1: ARM, trigger coincident with a strobe, single shot to DONE
        i_mode   = 1'b1;
        i_enable = 1'b1;
        tick();
        chk("arm_state", 64'(o_debug_state), 64'd1);
        strobe(24'h000AAA, 24'd1, 1'b0, 0);
        strobe(24'h000AAB, 24'd2, 1'b0, 0);
        chk("arm_hold", 64'(o_debug_state), 64'd1);
        strobe_x(24'h000BBB, 24'd3, 1'b0, 0, 1'b1, 2'b00, 1'b0, 0, 0);
        chk("trig_state", 64'(o_debug_state), 64'd2);
        for (int i = 0; i < 16; i++) strobe(24'(200 + i), 24'(i), 1'b1, i);
        chk("done_state", 64'(o_debug_state), 64'd3);
        for (int i = 0; i < 5; i++) strobe(24'(300 + i), 24'(i), 1'b0, 0);
        chk("done_hold",      64'(o_debug_state), 64'd3);
        chk("m1_no_overrun",  64'(o_overrun),     64'd0);
        i_enable = 1'b0;
        tick();
        clr_model();
        chk("m1_idle", 64'(o_debug_state), 64'd0);

        // Moving sum with hand-computed windows
        i_mode   = 1'b0;
        i_enable = 1'b1;
        tick();
        strobe_x(24'd4,      24'hFFFFFF, 1'b1, 0, 1'b0, 2'b00, 1'b1, 4,  -1);
        strobe_x(24'd4,      24'hFFFFFF, 1'b1, 1, 1'b0, 2'b00, 1'b1, 8,  -2);
        strobe_x(24'd4,      24'hFFFFFF, 1'b1, 2, 1'b0, 2'b00, 1'b1, 12, -3);
        strobe_x(24'd4,      24'hFFFFFF, 1'b1, 3, 1'b0, 2'b00, 1'b1, 16, -4);
        strobe_x(24'hFFFFF8, 24'hFFFFFF, 1'b1, 4, 1'b0, 2'b00, 1'b1, 4,  -4);

        // Reset mid-capture at pointer 5
        i_rst = 1'b1;
        tick();
        chk("rst2_addr",  64'(o_ram_addr),    64'd0);
        chk("rst2_ce",    64'(o_ram_ce),      64'd0);
        chk("rst2_we",    64'(o_ram_we),      64'd1);
        chk("rst2_dout",  64'(o_ram_dout),    64'd0);
        chk("rst2_flag1", 64'(o_flag_1),      64'd0);
        chk("rst2_flag2", 64'(o_flag_2),      64'd0);
        chk("rst2_sum",   64'(o_sum_data),    64'd0);
        chk("rst2_state", 64'(o_debug_state), 64'd0);
        i_rst = 1'b0;
        clr_model();
        tick();
        chk("rst2_restart", 64'(o_debug_state), 64'd2);
        strobe_x(24'd7, 24'd1, 1'b1, 0, 1'b0, 2'b00, 1'b1, 7,  1);
        strobe_x(24'd7, 24'd1, 1'b1, 1, 1'b0, 2'b00, 1'b1, 14, 2);

        i_enable = 1'b0;
        repeat (3) tick();
        chk("wr_queue_drained",  64'(wq.size()), 64'd0);
        chk("sum_queue_drained", 64'(sq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
- Parametrised N-channel ADC capture controller, the successor to the fixed dual-channel AD4030/ADS8689 capture logic.
- Takes packed per-sample data from the SPI front-ends and writes raw samples into a ping-pong DPBRAM of configurable depth.
- Raises half and full flags with PS acknowledge and overrun detection, and supports continuous or triggered single-shot capture.
- Computes a per-channel moving sum, over a configurable power-of-two window, for the floating-point and INTL paths.

Parameters:
- NCH, 2, number of ADC channels sharing one sample strobe.
- DW, 24, raw sample width per channel, two's complement.
- RAM_DEPTH, 20000, DPBRAM depth in samples; must be even and ≥4.
- SUM_LOG2, 3, moving-sum window = 2^SUM_LOG2 samples; DW+SUM_LOG2 ≤ 32.
- AW, $clog2(RAM_DEPTH), RAM address width.

Ports:
- i_clk  in  1  system clock (200 MHz).
- i_rst  in  1  synchronous active-high reset.
- i_enable  in  1  capture/sum enable; low = idle and clear.
- i_mode  in  1  0 = continuous ping-pong, 1 = triggered single-shot.
- i_trig  in  1  single-shot trigger pulse.
- i_smp_valid  in  1  one-cycle strobe; all channels valid together.
- i_smp_data  in  NCH*DW  packed samples; ch0 in LSBs.
- i_flag_ack  in  2  PS acknowledge; [0] first half, [1] second half.
- o_ram_addr  out  AW  DPBRAM port-A address.
- o_ram_ce  out  1  DPBRAM chip enable (write strobe).
- o_ram_we  out  1  constant 1.
- o_ram_dout  out  NCH*DW  registered copy of i_smp_data.
- o_flag_1  out  1  first half [0..RAM_DEPTH/2-1] ready.
- o_flag_2  out  1  second half ready.
- o_overrun  out  1  sticky: a flag re-asserted before it was acked.
- o_sum_data  out  NCH*32  per-channel moving sums, sign-extended.
- o_sum_valid  out  1  one-cycle pulse when o_sum_data updates.
- o_debug_state  out  2  current FSM state.

Behaviour:
- Reset: all outputs 0 except o_ram_we = 1. State IDLE, address 0, sum history cleared.
- FSM states:
  - IDLE (0): enter CAPTURE when i_enable=1 and i_mode=0; enter ARM when i_enable=1 and i_mode=1.
  - ARM (1): enter CAPTURE on i_trig.
  - CAPTURE (2): write samples.
  - DONE (3): entered in mode 1 after the write at RAM_DEPTH-1; exits to IDLE only when i_enable=0.
- i_enable=0 in any state: IDLE on the next cycle, address cleared to 0. Flags and o_overrun are kept; o_overrun clears on the next IDLE→active transition.
- Write, CAPTURE only: on i_smp_valid, the next cycle drives o_ram_ce=1 for one cycle with the current address and registered data (latency 1). Address increments after each write.
  - Mode 0: address wraps from RAM_DEPTH-1 to 0.
  - Mode 1: last write is at RAM_DEPTH-1, then DONE.
- A trigger and a sample strobe in the same cycle in ARM: the sample is not captured; capture starts with the next strobe.
- Flags:
  - o_flag_1 sets in the cycle its write is at address RAM_DEPTH/2-1.
  - o_flag_2 sets in the cycle its write is at address RAM_DEPTH-1.
  - i_flag_ack[k] clears the corresponding flag the next cycle.
- Overrun: a set while the flag is already 1 and unacked sets o_overrun.
- Set and ack in the same cycle: flag stays 1, no overrun.
- Moving sum (runs whenever i_enable=1, independent of FSM):
  - Per channel, a 2^SUM_LOG2-deep history shift register.
  - On each strobe: sum ← sum + sext(new) − sext(oldest).
  - o_sum_data and o_sum_valid update one cycle after i_smp_valid.
  - During the first 2^SUM_LOG2 samples after enable, oldest = 0 (partial sum).
  - Sum width is 32 bits; no saturation is needed given the parameter constraint.
- i_enable=0 clears the history and sums to 0.
- Reset mid-capture: identical to power-on reset, taking effect on the next edge.

Test Plan (NCH=2, DW=24, RAM_DEPTH=16, SUM_LOG2=2):
- Mode 0, 16 strobes with ch0 = index, ch1 = 0xFFFFFF; no ack.
  - Required: writes at addresses 0..15 with the matching data, o_flag_1 rises after addr 7, o_flag_2 rises after addr 15.
  - 8 further strobes: o_overrun=1.
- Mode 0 with an ack pulse in the same cycle as the second flag_1 set → o_flag_1 stays 1, o_overrun stays 0. An ack with no set → flag clears the next cycle.
- Mode 1: no writes before i_trig. A trigger coincident with a strobe → that sample is skipped. After 16 captured samples → state DONE (3), o_ram_ce stays 0 for 5 extra strobes. i_enable=0 → IDLE.
- Moving sum, ch0 samples 4,4,4,4,−8 (0xFFFFF8) → o_sum_data[31:0] = 4,8,12,16,4, each pulse one cycle after its strobe. ch1 = −1 constant → −1,−2,−3,−4,−4.
- i_rst pulsed at address 5 mid-capture → all outputs 0 the next cycle. Re-enable → writes restart at address 0, sums restart from 0.
- i_enable dropped at address 9 with o_flag_1=1 → IDLE, address 0, o_flag_1 still 1. Re-enable → o_overrun cleared.
